uff_bank_ctrl: RTL and testbench

Command-driven controller for a bank of WIDTH universal flip-flops. Each accepted command selects a flip-flop personality (D, T, JK, SR), converts the command inputs into D-input excitation, and applies it to masked bits of the stored state. The block sequences the D-to-JK/T/SR conversion datapath behind a valid/ready command port and a valid/ready response port. It sits between a stimulus or sequencing master and any logic consuming the flip-flop state `q`.

---
 rtl/uff_pkg.sv | 23 ++
 rtl/uff_excite.sv | 54 +++++
 rtl/uff_bank_ctrl.sv | 134 +++++++++++++
 tb/tb_uff_bank_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uff_pkg.sv
// -----------------------------------------------------------------------------
// uff_pkg
// Shared types for the universal flip-flop bank controller.
//   uff_mode_e  : flip-flop personality selected by a command (D, T, JK, SR)
//   uff_state_e : controller sequencing states (IDLE, EXEC, RESP)
// No ports; imported by uff_excite and uff_bank_ctrl.
// -----------------------------------------------------------------------------
package uff_pkg;

  typedef enum logic [1:0] {
    UFF_D  = 2'b00,
    UFF_T  = 2'b01,
    UFF_JK = 2'b10,
    UFF_SR = 2'b11
  } uff_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } uff_state_e;

endpackage

// File: rtl/uff_excite.sv
// -----------------------------------------------------------------------------
// uff_excite
// Purely combinational conversion of a flip-flop personality's inputs into
// the D-input excitation for every bit of the bank.
//   mode     in  personality (D/T/JK/SR)
//   a        in  D / T / J / S operand
//   b        in  K / R operand (unused for D and T)
//   q        in  current bank state
//   d        out next-state excitation per bit
//   errbits  out bits that must not be updated (SR with S=R=1)
//   mode_err out the selected personality is not available in this build
// Build option: UFF_SR_MODE_EN enables SR excitation; without it mode 11 is
// rejected (all bits flagged, mode_err set) and no SR logic exists.
// -----------------------------------------------------------------------------
module uff_excite
  import uff_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  uff_mode_e        mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] errbits,
  output logic             mode_err
);

  // Per-personality characteristic equations expressed as D excitation.
  always_comb begin
    d        = q;
    errbits  = {WIDTH{1'b0}};
    mode_err = 1'b0;
    case (mode)
      UFF_D:  d = a;
      UFF_T:  d = q ^ a;
      UFF_JK: d = (a & ~q) | (~b & q);
      UFF_SR: begin
`ifdef UFF_SR_MODE_EN
        // S=R=1 is the forbidden input; those bits are flagged and held.
        d       = a | (~b & q);
        errbits = a & b;
`else
        // SR unavailable: flag every bit so nothing updates.
        d        = q;
        errbits  = {WIDTH{1'b1}};
        mode_err = 1'b1;
`endif
      end
      default: d = q;
    endcase
  end

endmodule

// File: rtl/uff_bank_ctrl.sv
// -----------------------------------------------------------------------------
// uff_bank_ctrl
// Command-driven controller for a bank of WIDTH universal flip-flops.
// A command is latched in IDLE, applied to the masked bits in EXEC and its
// result is offered on the response port in RESP.
//   clk, rst              clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake
//   cmd_mode/a/b/mask     personality, operands and per-bit update mask
//   q                     flip-flop bank state
//   rsp_valid/rsp_ready   response handshake
//   rsp_q, rsp_err        q after the command, illegal-condition flag
//   busy                  controller is not IDLE
// Build option: UFF_SR_MODE_EN (see uff_excite) enables the SR personality.
// -----------------------------------------------------------------------------
module uff_bank_ctrl
  import uff_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_mode,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [WIDTH-1:0] cmd_mask,
  output logic [WIDTH-1:0] q,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_q,
  output logic             rsp_err,
  output logic             busy
);

  uff_state_e       state_q, state_d;
  uff_mode_e        mode_q, mode_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] bank_q, bank_d;
  logic [WIDTH-1:0] rsp_q_q, rsp_q_d;
  logic             rsp_err_q, rsp_err_d;

  logic [WIDTH-1:0] exc_d;
  logic [WIDTH-1:0] exc_err;
  logic             exc_mode_err;
  logic [WIDTH-1:0] upd;

  // Excitation works only from latched operands, so cmd_* never reach q.
  uff_excite #(.WIDTH(WIDTH)) u_excite (
    .mode     (mode_q),
    .a        (a_q),
    .b        (b_q),
    .q        (bank_q),
    .d        (exc_d),
    .errbits  (exc_err),
    .mode_err (exc_mode_err)
  );

  assign upd = mask_q & ~exc_err;

  // Next-state, operand latching and response capture.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    a_d       = a_q;
    b_d       = b_q;
    mask_d    = mask_q;
    bank_d    = bank_q;
    rsp_q_d   = rsp_q_q;
    rsp_err_d = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          mode_d  = uff_mode_e'(cmd_mode);
          a_d     = cmd_a;
          b_d     = cmd_b;
          mask_d  = cmd_mask;
          state_d = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        bank_d    = (exc_d & upd) | (bank_q & ~upd);
        rsp_q_d   = (exc_d & upd) | (bank_q & ~upd);
        // An unavailable personality is an error even with an empty mask.
        rsp_err_d = (|(exc_err & mask_q)) | exc_mode_err;
        state_d   = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset wins over a same-edge EXEC update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mode_q    <= UFF_D;
      a_q       <= {WIDTH{1'b0}};
      b_q       <= {WIDTH{1'b0}};
      mask_q    <= {WIDTH{1'b0}};
      bank_q    <= {WIDTH{1'b0}};
      rsp_q_q   <= {WIDTH{1'b0}};
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      a_q       <= a_d;
      b_q       <= b_d;
      mask_q    <= mask_d;
      bank_q    <= bank_d;
      rsp_q_q   <= rsp_q_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  // Handshake flags decode directly from the state register.
  assign cmd_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign q         = bank_q;
  assign rsp_q     = rsp_q_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_uff_bank_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uff_bank_ctrl
// Self-checking bench for uff_bank_ctrl (WIDTH=4): directed vector table,
// hand-written multi-cycle sequences, and random commands checked against a
// per-bit truth-table model of the flip-flop personalities.
// -----------------------------------------------------------------------------
module tb_uff_bank_ctrl;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_mode;
  logic [W-1:0] cmd_a;
  logic [W-1:0] cmd_b;
  logic [W-1:0] cmd_mask;
  logic [W-1:0] q;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_q;
  logic         rsp_err;
  logic         busy;

  int    checks;
  int    errors;
  string cur_tag;
  logic [W-1:0] q_m;

  uff_bank_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_mode  (cmd_mode),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_mask  (cmd_mask),
    .q         (q),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_q     (rsp_q),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   mode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] mask;
    logic [W-1:0] exp_q;
    logic         exp_err;
  } vec_t;

  vec_t tbl [7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %0h expected %0h", cur_tag, name, act, exp);
    end
  endtask

  // Reference: per-bit personality truth tables. Returns {err, next_q}.
  function automatic logic [W:0] ref_step(input logic [1:0] mode, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic [W-1:0] mask,
                                          input logic [W-1:0] cur);
    logic [W-1:0] n;
    logic err;
    n = cur;
    err = 1'b0;
`ifndef UFF_SR_MODE_EN
    if (mode == 2'b11) err = 1'b1;
`endif
    for (int i = 0; i < W; i++) begin
      if (mask[i]) begin
        case (mode)
          2'b00: n[i] = a[i];
          2'b01: if (a[i]) n[i] = ~cur[i];
          2'b10: begin
            if (a[i] && b[i]) n[i] = ~cur[i];
            else if (a[i]) n[i] = 1'b1;
            else if (b[i]) n[i] = 1'b0;
          end
          default: begin
`ifdef UFF_SR_MODE_EN
            if (a[i] && b[i]) err = 1'b1;
            else if (a[i]) n[i] = 1'b1;
            else if (b[i]) n[i] = 1'b0;
`endif
          end
        endcase
      end
    end
    return {err, n};
  endfunction

  // Full command transaction with per-edge checks; stall = cycles rsp_ready held low.
  task automatic run_cmd(input logic [1:0] mode, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] mask, input int stall,
                         input logic [W-1:0] exp_q, input logic exp_err);
    int n;
    n = 0;
    while (!cmd_ready && n < 10) begin
      step();
      n++;
    end
    check("ready_wait", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_mode  = mode;
    cmd_a     = a;
    cmd_b     = b;
    cmd_mask  = mask;
    step();                                     // E0: accepted
    check("busy_e0", {31'd0, busy}, 32'd1);
    check("cmd_ready_e0", {31'd0, cmd_ready}, 32'd0);
    cmd_valid = 1'b0;
    cmd_a     = ~a;                             // operands must already be latched
    cmd_mask  = ~mask;
    step();                                     // E1: q updated, response up
    check("q", {28'd0, q}, {28'd0, exp_q});
    check("rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("rsp_q", {28'd0, rsp_q}, {28'd0, exp_q});
    check("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
    check("cmd_ready_e1", {31'd0, cmd_ready}, 32'd0);
    for (int s = 0; s < stall; s++) begin
      step();
      check("stall_valid", {31'd0, rsp_valid}, 32'd1);
      check("stall_rsp_q", {28'd0, rsp_q}, {28'd0, exp_q});
      check("stall_rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
    end
    rsp_ready = 1'b1;
    step();                                     // E2: response handshake
    rsp_ready = 1'b0;
    check("rsp_valid_e2", {31'd0, rsp_valid}, 32'd0);
    check("cmd_ready_e2", {31'd0, cmd_ready}, 32'd1);
    check("busy_e2", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [W:0] r;
    checks    = 0;
    errors    = 0;
    cur_tag   = "reset";
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_mode  = 2'b00;
    cmd_a     = 4'b0000;
    cmd_b     = 4'b0000;
    cmd_mask  = 4'b0000;
    rsp_ready = 1'b0;
    repeat (2) step();
    check("q", {28'd0, q}, 32'd0);
    check("rsp_q", {28'd0, rsp_q}, 32'd0);
    check("rsp_err", {31'd0, rsp_err}, 32'd0);
    check("rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("busy", {31'd0, busy}, 32'd0);
    check("cmd_ready", {31'd0, cmd_ready}, 32'd1);
    rst = 1'b0;
    step();

    // Directed table: expected results worked out by hand.
    tbl[0] = '{2'b00, 4'b1010, 4'b0000, 4'b1111, 4'b1010, 1'b0};  // D
    tbl[1] = '{2'b01, 4'b1111, 4'b0000, 4'b0011, 4'b1001, 1'b0};  // T masked
    tbl[2] = '{2'b00, 4'b0011, 4'b1111, 4'b1111, 4'b0011, 1'b0};  // D preload
    tbl[3] = '{2'b10, 4'b0101, 4'b0110, 4'b1111, 4'b0101, 1'b0};  // JK hold/toggle/reset/set
    tbl[4] = '{2'b00, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 1'b0};  // D clear
`ifdef UFF_SR_MODE_EN
    tbl[5] = '{2'b11, 4'b1100, 4'b0101, 4'b1111, 4'b1000, 1'b1};  // SR, bit2 illegal
    tbl[6] = '{2'b00, 4'b1111, 4'b0000, 4'b0000, 4'b1000, 1'b0};  // mask=0
`else
    tbl[5] = '{2'b11, 4'b1100, 4'b0101, 4'b1111, 4'b0000, 1'b1};  // SR unavailable
    tbl[6] = '{2'b00, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b0};  // mask=0
`endif
    for (int i = 0; i < 7; i++) begin
      cur_tag = $sformatf("vec%0d", i);
      run_cmd(tbl[i].mode, tbl[i].a, tbl[i].b, tbl[i].mask, 0, tbl[i].exp_q, tbl[i].exp_err);
    end
    q_m = tbl[6].exp_q;

    // rsp_ready while idle does nothing.
    cur_tag = "idle_rsp_ready";
    rsp_ready = 1'b1;
    repeat (2) step();
    check("rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("q", {28'd0, q}, {28'd0, q_m});
    rsp_ready = 1'b0;

    // Back-pressure with a second command waiting.
    cur_tag = "backpressure";
    cmd_valid = 1'b1; cmd_mode = 2'b00; cmd_a = 4'b0101; cmd_b = 4'b0000; cmd_mask = 4'b1111;
    step();
    cmd_mode = 2'b01; cmd_a = 4'b1111; cmd_mask = 4'b1111;
    step();
    check("rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("q", {28'd0, q}, 32'h5);
    for (int s = 0; s < 5; s++) begin
      step();
      check("hold_valid", {31'd0, rsp_valid}, 32'd1);
      check("hold_rsp_q", {28'd0, rsp_q}, 32'h5);
      check("hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      check("hold_q", {28'd0, q}, 32'h5);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("hs_valid", {31'd0, rsp_valid}, 32'd0);
    check("hs_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("hs_q", {28'd0, q}, 32'h5);
    step();
    check("second_accept", {31'd0, busy}, 32'd1);
    cmd_valid = 1'b0;
    step();
    check("second_q", {28'd0, q}, 32'hA);
    check("second_rsp_q", {28'd0, rsp_q}, 32'hA);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("second_done", {31'd0, rsp_valid}, 32'd0);

    // Reset while the response is pending.
    cur_tag = "rst_resp";
    cmd_valid = 1'b1; cmd_mode = 2'b00; cmd_a = 4'b1111; cmd_mask = 4'b1111;
    step();
    cmd_valid = 1'b0;
    step();
    check("rsp_valid_pre", {31'd0, rsp_valid}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("q", {28'd0, q}, 32'd0);
    check("cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("busy", {31'd0, busy}, 32'd0);
    step();
    check("no_rsp", {31'd0, rsp_valid}, 32'd0);

    // Reset on the same edge the EXEC update would land.
    cur_tag = "rst_exec";
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("q", {28'd0, q}, 32'd0);
    check("busy", {31'd0, busy}, 32'd0);
    check("rsp_valid", {31'd0, rsp_valid}, 32'd0);
    q_m = 4'b0000;
    step();

    // Random commands against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [1:0]   m;
      logic [W-1:0] ra, rb, rm;
      m  = 2'($urandom_range(0, 3));
      ra = 4'($urandom);
      rb = 4'($urandom);
      rm = 4'($urandom);
      r  = ref_step(m, ra, rb, rm, q_m);
      cur_tag = $sformatf("rand%0d", i);
      run_cmd(m, ra, rb, rm, $urandom_range(0, 3), r[W-1:0], r[W]);
      q_m = r[W-1:0];
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
